wr_queue: RTL and testbench
===========================

WR_QUEUE -- requirements
Module: wr_queue

Interface
REQ-001 Parameter D_BYTES_PER_LINE, default 16, cache line size in bytes.
REQ-002 Parameter DEPTH, default 4, number of queued write entries; power of two, at least 2.
REQ-003 Parameter D_LINE_WIDTH, default D_BYTES_PER_LINE*8, line data width in bits.
REQ-004 The ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- push_req  in  1  d cache write request.
- push_rdy  out  1  queue can accept the request.
- push_burst  in  1  1 = full-line writeback; 0 = single uncached store.
- push_data  in  D_LINE_WIDTH  line data; a single store uses bits [31:0].
- push_addr  in  32  byte address.
- push_size  in  2  AXI size, single store only.
- push_strb  in  4  byte strobes, single store only.
- wr_req  out  1  one-cycle capture pulse to the AXI write stage.
- wr_rdy  in  1  AXI write stage can capture.
- burst, data, addr, size, strb  out  1/D_LINE_WIDTH/32/2/4  head entry fields.
- b_done  in  1  B-channel handshake (bvalid & bready).
- lookup_addr  in  32  read-miss address to check.
- lookup_hit  out  1  a pending write overlaps the lookup_addr line.
- drained  out  1  the queue is empty and no write is outstanding.

Function
REQ-005 The queue SHALL be an in-order FIFO of DEPTH entries, each holding {burst, data, addr, size, strb}.
REQ-006 push_rdy SHALL equal ~full; there is no bypass of a full queue, even when a pop happens in the same cycle.
- A push is accepted on push_req & push_rdy.
- push_req while full is ignored, and the queue is unchanged.
REQ-007 wr_req SHALL equal ~empty & wr_rdy & (outstanding < 2).
- The head entry pops in the same cycle wr_req is high.
- burst, data, addr, size and strb SHALL always show the head entry, with zero latency.
REQ-008 A simultaneous push and pop SHALL keep the count unchanged.
- A push into an empty queue becomes visible on the outputs the next cycle.
REQ-009 The outstanding counter (2 bits, range 0..2) SHALL count writes popped and not yet completed.
- It increments on pop and decrements on b_done.
- When both happen in one cycle it is unchanged.
- b_done while the counter is 0 is ignored; the counter saturates at 0.
REQ-010 A 2-entry in-flight address ring SHALL record the addr of each pop; the oldest slot retires on b_done.
REQ-011 lookup_hit SHALL be combinational and SHALL be 1 when lookup_addr[31:log2(D_BYTES_PER_LINE)] matches the same bits of:
- any valid queue entry, or
- any valid in-flight slot.
REQ-012 drained SHALL equal empty & (outstanding == 0).
REQ-013 Pointers SHALL wrap modulo DEPTH.
- full and empty SHALL be derived from pointers that carry one extra wrap bit.

Reset
REQ-014 While resetn is low, the block SHALL clear immediately (asynchronously):
- the pointers,
- the outstanding count,
- all in-flight valid bits.
REQ-015 Output values during and after reset SHALL be:
- push_rdy=1, wr_req=0, lookup_hit=0, drained=1.
- Data storage is not reset.
REQ-016 A reset in the middle of an operation SHALL discard all queued and in-flight state without emitting any further wr_req.

Configuration
REQ-017 The macro WR_QUEUE_MERGE_EN, when defined, SHALL enable store merging. A non-burst push merges into the tail entry instead of allocating a new entry when all of the following hold:
- the tail entry is non-burst,
- both sizes are 2'b10,
- the word addresses are equal,
- the tail entry is not popping in the same cycle.
REQ-018 A merge SHALL update the tail entry as follows:
- byte i of the tail data is replaced wherever push_strb[i] is 1;
- the tail strb becomes the OR of the old strb and push_strb;
- the count is unchanged.
- A merge is accepted even when the queue is full.
REQ-019 Without WR_QUEUE_MERGE_EN, every accepted push SHALL allocate a new entry.

Structure
REQ-020 A shared cache package SHALL hold:
- the line-address LSB constant,
- the AXI size encodings,
- the entry field widths,
- all shared with the AXI read and write stages.
REQ-021 One sub-module, line_cam, SHALL implement the line-address comparison over the queue entries plus the in-flight slots and produce lookup_hit.

Verification
REQ-022 Reset, then push 4 bursts to 0x100, 0x110, 0x120 and 0x130 with wr_rdy=0:
- push_rdy falls after the 4th push,
- a 5th push is ignored.
REQ-023 Raise wr_rdy:
- wr_req pulses with addr 0x100 and then 0x110,
- a third pulse is withheld until b_done brings outstanding below 2.
REQ-024 Queue holds 0x1234_0010 in flight and lookup_addr=0x1234_001C:
- lookup_hit=1.
- After b_done, lookup_hit=0 and drained=1.
REQ-025 With WR_QUEUE_MERGE_EN defined, push two word stores to 0x80:
- strb 0011 with data 0xAAAA_1111, then strb 1100 with data 0x2222_BBBB.
- A single entry results, with data 0x2222_1111 and strb 1111.
REQ-026 Assert resetn=0 mid-burst with 3 entries queued and 2 outstanding:
- drained=1 and push_rdy=1 immediately,
- no wr_req after release.

Source files
------------

// File: rtl/wr_queue_pkg.sv
// wr_queue_pkg -- cache-side constants shared by the write queue and the AXI
// read/write stages: line-address LSB, AXI size encodings and entry field
// widths.
package wr_queue_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned SIZE_W         = 2;
  localparam int unsigned STRB_W         = 4;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_LINE = 16;
  // Lowest address bit that selects a cache line.
  localparam int unsigned LINE_LSB       = $clog2(BYTES_PER_LINE);
  // Maximum number of writes allowed past the queue awaiting a B response.
  localparam int unsigned OUTST_MAX      = 2;

  typedef enum logic [SIZE_W-1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } axi_size_e;

endpackage

// File: rtl/wr_queue_line_cam.sv
// line_cam -- combinational line-address match of one lookup address against
// N tagged address slots.
//   addr_i        : N slot addresses (byte addresses)
//   vld_i         : per-slot valid
//   lookup_addr_i : address to test
//   hit_o         : some valid slot shares the lookup line
module line_cam
  import wr_queue_pkg::*;
#(
  parameter int N   = 6,
  parameter int LSB = LINE_LSB
) (
  input  logic [N-1:0][ADDR_W-1:0] addr_i,
  input  logic [N-1:0]             vld_i,
  input  logic [ADDR_W-1:0]        lookup_addr_i,
  output logic                     hit_o
);

  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vld_i[i] && ((addr_i[i] >> LSB) == (lookup_addr_i >> LSB))) begin
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wr_queue.sv
// wr_queue -- in-order write queue between the D cache and the AXI write
// stage, with a 2-deep in-flight address ring so read misses can detect a
// pending write to the same line.
//   clk, resetn         : clock, asynchronous active-low reset
//   push_*              : write request from the D cache (push_rdy = ~full)
//   wr_req / wr_rdy     : one-cycle capture pulse to the AXI write stage
//   burst..strb         : head entry fields, zero latency
//   b_done              : B-channel handshake, retires the oldest in-flight write
//   lookup_addr/_hit    : line match against queued and in-flight writes
//   drained             : empty and nothing outstanding
// Optional: define WR_QUEUE_MERGE_EN to merge word stores into the tail entry.
module wr_queue
  import wr_queue_pkg::*;
#(
  parameter int D_BYTES_PER_LINE = 16,
  parameter int DEPTH            = 4,
  parameter int D_LINE_WIDTH     = D_BYTES_PER_LINE * 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    push_req,
  output logic                    push_rdy,
  input  logic                    push_burst,
  input  logic [D_LINE_WIDTH-1:0] push_data,
  input  logic [ADDR_W-1:0]       push_addr,
  input  logic [SIZE_W-1:0]       push_size,
  input  logic [STRB_W-1:0]       push_strb,
  output logic                    wr_req,
  input  logic                    wr_rdy,
  output logic                    burst,
  output logic [D_LINE_WIDTH-1:0] data,
  output logic [ADDR_W-1:0]       addr,
  output logic [SIZE_W-1:0]       size,
  output logic [STRB_W-1:0]       strb,
  input  logic                    b_done,
  input  logic [ADDR_W-1:0]       lookup_addr,
  output logic                    lookup_hit,
  output logic                    drained
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LSB = $clog2(D_BYTES_PER_LINE);

  // Entry storage is deliberately not reset.
  logic                    burst_mem [DEPTH];
  logic [D_LINE_WIDTH-1:0] data_mem  [DEPTH];
  logic [ADDR_W-1:0]       addr_mem  [DEPTH];
  logic [SIZE_W-1:0]       size_mem  [DEPTH];
  logic [STRB_W-1:0]       strb_mem  [DEPTH];

  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic [1:0]        outst_q, outst_d;
  logic              empty, full, pop, alloc, merge, retire;

  logic [ADDR_W-1:0] if_addr_q [2];
  logic [1:0]        if_vld_q, if_vld_d;
  logic              if_wp_q, if_wp_d, if_rp_q, if_rp_d;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign cnt    = wr_ptr_q - rd_ptr_q;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  // Same index with opposite wrap bits means every slot is occupied.
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

  assign push_rdy = ~full;
  assign pop      = ~empty & wr_rdy & (outst_q < 2'(OUTST_MAX));
  assign wr_req   = pop;
  assign retire   = b_done & (outst_q != 2'd0);
  assign drained  = empty & (outst_q == 2'd0);

`ifdef WR_QUEUE_MERGE_EN
  logic [AW-1:0] tail_idx;
  assign tail_idx = wr_idx - 1'b1;
  // A tail that is also the popping head is already leaving; allocate instead.
  assign merge = push_req & ~push_burst & ~empty & ~burst_mem[tail_idx]
               & (size_mem[tail_idx] == SIZE_WORD) & (push_size == SIZE_WORD)
               & (addr_mem[tail_idx][ADDR_W-1:2] == push_addr[ADDR_W-1:2])
               & ~(pop & (cnt == (AW+1)'(1)));
`else
  assign merge = 1'b0;
`endif

  assign alloc = push_req & ~full & ~merge;

  assign burst = burst_mem[rd_idx];
  assign data  = data_mem[rd_idx];
  assign addr  = addr_mem[rd_idx];
  assign size  = size_mem[rd_idx];
  assign strb  = strb_mem[rd_idx];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(alloc);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    outst_d  = outst_q;
    case ({pop, retire})
      2'b10:   outst_d = outst_q + 2'd1;
      2'b01:   outst_d = outst_q - 2'd1;
      default: outst_d = outst_q;
    endcase
    if_vld_d = if_vld_q;
    if_wp_d  = if_wp_q;
    if_rp_d  = if_rp_q;
    // Pop and retire in one cycle always touch different slots: a pop needs
    // outstanding < 2 and a retire needs outstanding > 0.
    if (pop) begin
      if_vld_d[if_wp_q] = 1'b1;
      if_wp_d           = ~if_wp_q;
    end
    if (retire) begin
      if_vld_d[if_rp_q] = 1'b0;
      if_rp_d           = ~if_rp_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      outst_q  <= '0;
      if_vld_q <= '0;
      if_wp_q  <= 1'b0;
      if_rp_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      outst_q  <= outst_d;
      if_vld_q <= if_vld_d;
      if_wp_q  <= if_wp_d;
      if_rp_q  <= if_rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      burst_mem[wr_idx] <= push_burst;
      data_mem[wr_idx]  <= push_data;
      addr_mem[wr_idx]  <= push_addr;
      size_mem[wr_idx]  <= push_size;
      strb_mem[wr_idx]  <= push_strb;
    end
`ifdef WR_QUEUE_MERGE_EN
    if (merge) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (push_strb[b]) data_mem[tail_idx][8*b +: 8] <= push_data[8*b +: 8];
      end
      strb_mem[tail_idx] <= strb_mem[tail_idx] | push_strb;
    end
`endif
    if (pop) if_addr_q[if_wp_q] <= addr_mem[rd_idx];
  end

  // Queue entries are valid when their offset from the head is below count.
  logic [DEPTH+1:0][ADDR_W-1:0] cam_addr;
  logic [DEPTH+1:0]             cam_vld;
  logic [AW-1:0]                off;

  always_comb begin
    cam_addr = '0;
    cam_vld  = '0;
    off      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off         = AW'(i) - rd_idx;
      cam_addr[i] = addr_mem[i];
      cam_vld[i]  = ({1'b0, off} < cnt);
    end
    cam_addr[DEPTH]   = if_addr_q[0];
    cam_vld[DEPTH]    = if_vld_q[0];
    cam_addr[DEPTH+1] = if_addr_q[1];
    cam_vld[DEPTH+1]  = if_vld_q[1];
  end

  line_cam #(
    .N   (DEPTH + 2),
    .LSB (LSB)
  ) u_line_cam (
    .addr_i        (cam_addr),
    .vld_i         (cam_vld),
    .lookup_addr_i (lookup_addr),
    .hit_o         (lookup_hit)
  );

endmodule

// File: tb/tb_wr_queue.sv
// tb_wr_queue -- directed self-checking bench for wr_queue (default params).
module tb_wr_queue;

  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          resetn;
  logic          push_req, push_rdy, push_burst;
  logic [LW-1:0] push_data;
  logic [31:0]   push_addr;
  logic [1:0]    push_size;
  logic [3:0]    push_strb;
  logic          wr_req, wr_rdy;
  logic          burst;
  logic [LW-1:0] data;
  logic [31:0]   addr;
  logic [1:0]    size;
  logic [3:0]    strb;
  logic          b_done;
  logic [31:0]   lookup_addr;
  logic          lookup_hit, drained;

  int checks = 0;
  int errors = 0;
  int pulses;

  wr_queue dut (
    .clk         (clk),
    .resetn      (resetn),
    .push_req    (push_req),
    .push_rdy    (push_rdy),
    .push_burst  (push_burst),
    .push_data   (push_data),
    .push_addr   (push_addr),
    .push_size   (push_size),
    .push_strb   (push_strb),
    .wr_req      (wr_req),
    .wr_rdy      (wr_rdy),
    .burst       (burst),
    .data        (data),
    .addr        (addr),
    .size        (size),
    .strb        (strb),
    .b_done      (b_done),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .drained     (drained)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic b, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic [3:0] st);
    push_req   = 1'b1;
    push_burst = b;
    push_addr  = a;
    push_data  = {96'h0, d};
    push_size  = s;
    push_strb  = st;
    tick();
    push_req   = 1'b0;
  endtask

  task automatic look(input logic [31:0] a, input logic exp, input string tag);
    lookup_addr = a;
    #1;
    chk(tag, lookup_hit, exp);
  endtask

  initial begin
    resetn = 1'b0; push_req = 1'b0; push_burst = 1'b0; push_data = '0;
    push_addr = '0; push_size = '0; push_strb = '0; wr_rdy = 1'b0;
    b_done = 1'b0; lookup_addr = '0;
    #3;
    chk("rst_push_rdy", push_rdy, 1'b1);
    chk("rst_wr_req", wr_req, 1'b0);
    chk("rst_lookup_hit", lookup_hit, 1'b0);
    chk("rst_drained", drained, 1'b1);
    repeat (2) tick();
    resetn = 1'b1;
    #1;

    // Fill with four line writebacks while the write stage is stalled.
    for (int k = 0; k < 4; k++) begin
      push(1'b1, 32'h100 + 32'(16 * k), 32'(k + 1), 2'b00, 4'h0);
      chk($sformatf("fill_push_rdy_%0d", k), push_rdy, (k < 3) ? 1'b1 : 1'b0);
    end
    chk("fill_drained", drained, 1'b0);
    chk("fill_wr_req", wr_req, 1'b0);
    push(1'b1, 32'h140, 32'h5, 2'b00, 4'h0);
    chk("full_push_rdy", push_rdy, 1'b0);
    chk("full_head_addr", addr, 32'h100);
    look(32'h144, 1'b0, "full_ignored_hit");
    look(32'h13C, 1'b1, "full_tail_hit");

    // Drain: two pops, then throttled at two outstanding.
    wr_rdy = 1'b1;
    #1;
    chk("pop0_wr_req", wr_req, 1'b1);
    chk("pop0_addr", addr, 32'h100);
    chk("pop0_burst", burst, 1'b1);
    tick();
    chk("pop1_wr_req", wr_req, 1'b1);
    chk("pop1_addr", addr, 32'h110);
    tick();
    chk("throttle_wr_req", wr_req, 1'b0);
    chk("throttle_addr", addr, 32'h120);
    chk("throttle_push_rdy", push_rdy, 1'b1);
    tick();
    chk("throttle2_wr_req", wr_req, 1'b0);
    b_done = 1'b1;
    #1;
    chk("bdone_cycle_wr_req", wr_req, 1'b0);
    tick();
    b_done = 1'b0;
    #1;
    chk("pop2_wr_req", wr_req, 1'b1);
    chk("pop2_addr", addr, 32'h120);
    look(32'h11F, 1'b1, "inflight_hit");
    look(32'h10C, 1'b0, "retired_nohit");
    tick();
    wr_rdy = 1'b0;
    #1;
    chk("out2_wr_req", wr_req, 1'b0);

    // Three queued, two outstanding, then reset mid-operation.
    push(1'b1, 32'h140, 32'h6, 2'b00, 4'h0);
    push(1'b1, 32'h150, 32'h7, 2'b00, 4'h0);
    chk("pre_rst_drained", drained, 1'b0);
    wr_rdy = 1'b1;
    #1;
    chk("pre_rst_wr_req", wr_req, 1'b0);
    resetn = 1'b0;
    #1;
    chk("midrst_drained", drained, 1'b1);
    chk("midrst_push_rdy", push_rdy, 1'b1);
    chk("midrst_wr_req", wr_req, 1'b0);
    look(32'h130, 1'b0, "midrst_hit");
    tick();
    tick();
    resetn = 1'b1;
    pulses = 0;
    repeat (6) begin
      #1;
      if (wr_req) pulses++;
      tick();
    end
    chk("postrst_wr_pulses", pulses, 0);
    chk("postrst_drained", drained, 1'b1);

    // Single store lookup against queue and in-flight ring.
    push(1'b0, 32'h1234_0010, 32'hDEAD_BEEF, 2'b10, 4'hF);
    #1;
    chk("st_wr_req", wr_req, 1'b1);
    chk("st_addr", addr, 32'h1234_0010);
    chk("st_burst", burst, 1'b0);
    chk("st_size", size, 2'b10);
    chk("st_strb", strb, 4'hF);
    chk("st_data", data[31:0], 32'hDEAD_BEEF);
    look(32'h1234_001C, 1'b1, "st_queue_hit");
    tick();
    chk("st_popped_wr_req", wr_req, 1'b0);
    chk("st_popped_drained", drained, 1'b0);
    look(32'h1234_001C, 1'b1, "st_inflight_hit");
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    look(32'h1234_001C, 1'b0, "st_done_hit");
    chk("st_done_drained", drained, 1'b1);

    // Spurious b_done with nothing outstanding must not underflow.
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    chk("spur_drained", drained, 1'b1);
    push(1'b0, 32'h200, 32'h1, 2'b10, 4'hF);
    #1;
    chk("spur_wr_req", wr_req, 1'b1);
    tick();
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    chk("spur_final_drained", drained, 1'b1);

    // Two word stores to the same word.
    wr_rdy = 1'b0;
    push(1'b0, 32'h80, 32'hAAAA_1111, 2'b10, 4'b0011);
    push(1'b0, 32'h80, 32'h2222_BBBB, 2'b10, 4'b1100);
    #1;
`ifdef WR_QUEUE_MERGE_EN
    chk("merge_data", data[31:0], 32'h2222_1111);
    chk("merge_strb", strb, 4'b1111);
    wr_rdy = 1'b1;
    #1;
    chk("merge_wr_req", wr_req, 1'b1);
    tick();
    chk("merge_single_entry", wr_req, 1'b0);
    chk("merge_drained", drained, 1'b0);
`else
    chk("nomerge_data0", data[31:0], 32'hAAAA_1111);
    chk("nomerge_strb0", strb, 4'b0011);
    wr_rdy = 1'b1;
    tick();
    chk("nomerge_wr_req1", wr_req, 1'b1);
    chk("nomerge_data1", data[31:0], 32'h2222_BBBB);
    chk("nomerge_strb1", strb, 4'b1100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
